// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and helpers for the serializer/deserializer pair
//
// Purpose: FSM state type and the data_mod -> bit-count mapping used by the
//          serializer, the deserializer and their benches.
// Ports:   none (package).
package ser_pkg;

  typedef enum logic [0:0] {
    IDLE_S = 1'b0,
    WORK_S = 1'b1
  } ser_state_t;

  // A mod value of zero means "the whole word"; any other value is the count.
  function automatic int unsigned mod_to_len(input int unsigned mod, input int unsigned w);
    return (mod == 0) ? w : mod;
  endfunction

endpackage

// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - parallel-in / serial-out bus between source and serializer
//
// Purpose: bundles the word-side handshake and the serial output of the serializer.
// Ports:   data_i/data_mod_i/data_val_i  word, valid-bit count (0 = all), word valid
//          ser_data_o/ser_data_val_o     serial bit and its qualifier
//          busy_o                        transfer in progress, new words ignored
// Modports: master = word source / bench, slave = serializer.
interface serializer_if #(
  parameter int DATA_BUS_WIDTH = 16
);
  localparam int MOD_WIDTH = $clog2(DATA_BUS_WIDTH);

  logic [DATA_BUS_WIDTH-1:0] data_i;
  logic [MOD_WIDTH-1:0]      data_mod_i;
  logic                      data_val_i;
  logic                      ser_data_o;
  logic                      ser_data_val_o;
  logic                      busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i,
    input  ser_data_o, ser_data_val_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i,
    output ser_data_o, ser_data_val_o, busy_o
  );
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter, MSB first, one bit per clock
//
// Purpose: accepts a word plus valid-bit count while idle and emits the top N
//          bits MSB first on consecutive cycles, with ser_data_val_o/busy_o high
//          for exactly those N cycles.
// Ports:   clk_i   clock, all logic on posedge
//          srst_i  synchronous reset, active-high; aborts any word in flight
//          bus     serializer_if.slave (word in, serial bit/valid/busy out)
module serializer
  import ser_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  serializer_if.slave       bus
);
  localparam int MOD_WIDTH = $clog2(DATA_BUS_WIDTH);
  // One extra bit so a full-word count (W) fits without wrapping to zero.
  localparam int CNT_WIDTH = MOD_WIDTH + 1;

  ser_state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  logic                      work;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE_S: begin
        // Idle for at least one cycle after each word, so a word held on the
        // input is picked up the cycle after the previous word's last bit.
        if (bus.data_val_i) begin
          shift_d = bus.data_i;
          cnt_d   = CNT_WIDTH'(mod_to_len(32'(bus.data_mod_i), 32'(DATA_BUS_WIDTH)));
          state_d = WORK_S;
        end
      end
      WORK_S: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = IDLE_S;
        end
      end
      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // Outputs decode flops only: valid and busy are the WORK_S state bit, and the
  // serial bit is gated so it reads 0 whenever it is not qualified.
  assign work               = (state_q == WORK_S);
  assign bus.ser_data_val_o = work;
  assign bus.busy_o         = work;
  assign bus.ser_data_o     = work & shift_q[DATA_BUS_WIDTH-1];

endmodule
